// File: rtl/csa_pkg.sv
// Shared types and helpers for the block-serial carry-select adder.
package csa_pkg;

    // Sequencer states: waiting for a request, or walking the slices.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of the slice counter; never below one bit so a single-slice
    // configuration still has a legal register.
    function automatic int cnt_w(input int nblk);
        return (nblk <= 1) ? 1 : $clog2(nblk);
    endfunction

endpackage

// File: rtl/csa_slice.sv
// One BLK-bit slice evaluated under both carry-in hypotheses at once.
module csa_slice #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    output logic [BLK-1:0] sum0,
    output logic [BLK-1:0] sum1,
    output logic           cout0,
    output logic           cout1,
    output logic           cmsb0,
    output logic           cmsb1
);

    logic [BLK:0]   r0;
    logic [BLK:0]   r1;
    logic [BLK-1:0] p;

    assign p  = x ^ y;
    assign r0 = {1'b0, x} + {1'b0, y};
    assign r1 = {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, 1'b1};

    assign sum0  = r0[BLK-1:0];
    assign sum1  = r1[BLK-1:0];
    assign cout0 = r0[BLK];
    assign cout1 = r1[BLK];

    // Sum bit = propagate ^ carry-in, so the carry into the MSB falls out
    // of the sum without a second adder chain.
    assign cmsb0 = p[BLK-1] ^ sum0[BLK-1];
    assign cmsb1 = p[BLK-1] ^ sum1[BLK-1];

endmodule

// File: rtl/csa_seq_adder.sv
// Block-serial carry-select adder/subtractor: one BLK-bit slice per clock,
// registered carry picks between the two precomputed slice results.
module csa_seq_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v
);

    localparam int NBLK = WIDTH / BLK;
    localparam int KW   = cnt_w(NBLK);
    localparam logic [KW-1:0] K_LAST = KW'(NBLK - 1);

    generate
        if ((BLK < 1) || (BLK > WIDTH) || ((WIDTH % BLK) != 0)) begin : g_bad_param
            $error("csa_seq_adder: WIDTH must be a non-zero multiple of BLK");
        end
    endgenerate

    state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic          done_q, done_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic          cout_q, cout_d;
    logic          v_q, v_d;

    logic [NBLK-1:0][BLK-1:0] opa_q, opa_d;
    logic [NBLK-1:0][BLK-1:0] opb_q, opb_d;
    logic [NBLK-1:0][BLK-1:0] acc_q, acc_d;

    logic [BLK-1:0] sum0, sum1, sel_sum;
    logic           cout0, cout1, cmsb0, cmsb1, sel_c, sel_cmsb;
    logic           accept, last;

    csa_slice #(.BLK(BLK)) u_slice (
        .x     (opa_q[k_q]),
        .y     (opb_q[k_q]),
        .sum0  (sum0),
        .sum1  (sum1),
        .cout0 (cout0),
        .cout1 (cout1),
        .cmsb0 (cmsb0),
        .cmsb1 (cmsb1)
    );

    assign sel_sum  = carry_q ? sum1  : sum0;
    assign sel_c    = carry_q ? cout1 : cout0;
    assign sel_cmsb = carry_q ? cmsb1 : cmsb0;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (k_q == K_LAST);

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start only counts in IDLE, RUN lasts exactly NBLK cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs derived from state.
    always_comb begin
        busy = (state_q == RUN);
    end

    // Slice sequencing, operand capture and result commit.
    always_comb begin
        k_d     = k_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;
        done_d  = 1'b0;
        if (accept) begin
            // Subtraction is A + ~B + 1, with cin inverted into a borrow.
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = cin ^ sub;
            k_d     = '0;
            acc_d   = '0;
        end else if (state_q == RUN) begin
            acc_d[k_q] = sel_sum;
            carry_d    = sel_c;
            k_d        = k_q + KW'(1);
            if (last) begin
                k_d    = '0;
                s_d    = acc_d;
                cout_d = sel_c;
                v_d    = sel_cmsb ^ sel_c;
                done_d = 1'b1;
            end
        end
    end

    // Control and visible results; all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            k_q     <= k_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    // Operand and accumulator storage; contents are don't-care outside RUN.
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
        acc_q <= acc_d;
    end

    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign v    = v_q;

endmodule

// File: tb/tb_csa_seq_adder.sv
module tb_csa_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        v;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    csa_seq_adder #(.WIDTH(16), .BLK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .v     (v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) chk("busy_and_done", 32'(busy & done), 32'd0);
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("s", 32'(s), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.c));
                    chk("v", 32'(v), 32'(e.v));
                end
            end
        end
    end

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                         input logic tsub, input logic [15:0] es, input logic ec, input logic ev);
        int nb;
        int cyc;
        exp_t e;
        e.s = es; e.c = ec; e.v = ev;
        exp_q.push_back(e);
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A; cin = ~tcin; sub = ~tsub;
        nb = 0; cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) nb++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_cycles", 32'(nb), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // 1: reset with arbitrary inputs, including a start request
        rst = 1'b1; start = 1'b1; sub = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        #22;
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_v", 32'(v), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // 2: basic add
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        // 3: positive overflow, then negative overflow with carry (back-to-back)
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        // 4: subtraction, without and with borrow-in
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Reset mid-idle clears a non-zero result
        rst = 1'b1; #2;
        chk("idle_rst_s", 32'(s), 32'd0);
        chk("idle_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 5: carry through every slice; start re-asserted while busy is ignored
        begin
            exp_t e;
            int cyc;
            e.s = 16'h0001; e.c = 1'b1; e.v = 1'b0;
            exp_q.push_back(e);
            d0 = n_done;
            a = 16'hFFFF; b = 16'h0001; cin = 1'b1; sub = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            a = 16'h0100; b = 16'h0100; cin = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 0;
            while (cyc < 12) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("single_done", 32'(n_done - d0), 32'd1);
            chk("idle_after", 32'(busy), 32'd0);
        end

        // 6: reset mid-run discards the operation
        d0 = n_done;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #2;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
